// File: rtl/clock_set_controller.sv
// clock_set_controller
// Front-panel sequencer for a six-digit BCD clock. It switches the clock
// counter between free-running and hour/minute edit modes, edits the time from
// debounced button pulses, and issues a one-cycle parallel load on commit.
// Optional feature macro: BLINK_EN (blinks the digits being edited on each tick).
module clock_set_controller #(
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic       run_en,
  output logic       load,
  output logic [3:0] ld_h1,
  output logic [3:0] ld_h0,
  output logic [3:0] ld_m1,
  output logic [3:0] ld_m0,
  output logic [5:0] blank_mask,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // A zero timeout still needs a legal, non-empty counter.
  localparam int TW = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_S > 0) ? TIMEOUT_S - 1 : 0);

  state_t        state;
  logic [TW-1:0] to_cnt;

  logic       any_btn, step_inc, step_dec, timeout_hit;
  logic [3:0] hu1, hu0, hd1, hd0, mu1, mu0, md1, md0;
  logic [3:0] cap_h1, cap_h0, cap_m1, cap_m0;

  assign mode        = state;
  assign any_btn     = btn_mode | btn_inc | btn_dec;
  // inc and dec together cancel; btn_mode has priority in the FSM below.
  assign step_inc    = btn_inc & ~btn_dec;
  assign step_dec    = btn_dec & ~btn_inc;
  assign timeout_hit = (TIMEOUT_S != 0) && tick && !any_btn && (to_cnt == TO_LAST);

  // BCD step values for the edit registers and sanitised capture of the live time.
  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    if (ld_h1 == 4'd2 && ld_h0 == 4'd3) begin hu1 = 4'd0;          hu0 = 4'd0;          end
    else if (ld_h0 == 4'd9)              begin hu1 = ld_h1 + 4'd1; hu0 = 4'd0;          end
    else                                 begin hu1 = ld_h1;        hu0 = ld_h0 + 4'd1; end

    if (ld_h1 == 4'd0 && ld_h0 == 4'd0) begin hd1 = 4'd2;          hd0 = 4'd3;          end
    else if (ld_h0 == 4'd0)              begin hd1 = ld_h1 - 4'd1; hd0 = 4'd9;          end
    else                                 begin hd1 = ld_h1;        hd0 = ld_h0 - 4'd1; end

    if (ld_m1 == 4'd5 && ld_m0 == 4'd9) begin mu1 = 4'd0;          mu0 = 4'd0;          end
    else if (ld_m0 == 4'd9)              begin mu1 = ld_m1 + 4'd1; mu0 = 4'd0;          end
    else                                 begin mu1 = ld_m1;        mu0 = ld_m0 + 4'd1; end

    if (ld_m1 == 4'd0 && ld_m0 == 4'd0) begin md1 = 4'd5;          md0 = 4'd9;          end
    else if (ld_m0 == 4'd0)              begin md1 = ld_m1 - 4'd1; md0 = 4'd9;          end
    else                                 begin md1 = ld_m1;        md0 = ld_m0 - 4'd1; end

    if (cur_h0 <= 4'd9 && (cur_h1 < 4'd2 || (cur_h1 == 4'd2 && cur_h0 <= 4'd3))) begin
      cap_h1 = cur_h1; cap_h0 = cur_h0;
    end else begin
      cap_h1 = 4'd0;   cap_h0 = 4'd0;
    end

    if (cur_m0 <= 4'd9 && cur_m1 <= 4'd5) begin
      cap_m1 = cur_m1; cap_m0 = cur_m0;
    end else begin
      cap_m1 = 4'd0;   cap_m0 = 4'd0;
    end
  end

  // Mode sequencer, edit registers, timeout counter and registered strobes.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= RUN;
      run_en <= 1'b1;
      load   <= 1'b0;
      ld_h1  <= 4'd0;
      ld_h0  <= 4'd0;
      ld_m1  <= 4'd0;
      ld_m0  <= 4'd0;
      to_cnt <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          run_en <= 1'b1;
          if (btn_mode) begin
            state  <= SET_H;
            run_en <= 1'b0;
            ld_h1  <= cap_h1;
            ld_h0  <= cap_h0;
            ld_m1  <= cap_m1;
            ld_m0  <= cap_m0;
            to_cnt <= '0;
          end
        end
        SET_H, SET_M: begin
          if (any_btn)                   to_cnt <= '0;
          else if (tick && to_cnt != '1) to_cnt <= to_cnt + TW'(1);

          if (btn_mode) begin
            if (state == SET_H) begin
              state <= SET_M;
            end else begin
              state <= COMMIT;
              load  <= 1'b1;
            end
          end else if (timeout_hit) begin
            state  <= RUN;
            run_en <= 1'b1;
          end else if (step_inc) begin
            if (state == SET_H) begin ld_h1 <= hu1; ld_h0 <= hu0; end
            else                begin ld_m1 <= mu1; ld_m0 <= mu0; end
          end else if (step_dec) begin
            if (state == SET_H) begin ld_h1 <= hd1; ld_h0 <= hd0; end
            else                begin ld_m1 <= md1; ld_m0 <= md0; end
          end
        end
        COMMIT: begin
          state  <= RUN;
          run_en <= 1'b1;
        end
        default: begin
          state  <= RUN;
          run_en <= 1'b1;
        end
      endcase
    end
  end

`ifdef BLINK_EN
  // Blink phase lives in the mask bits of the field being edited; buttons force visible.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blank_mask <= 6'd0;
    end else begin
      case (state)
        SET_H: begin
          if (any_btn || timeout_hit) blank_mask <= 6'd0;
          else if (tick)              blank_mask <= {{2{~blank_mask[5]}}, 4'd0};
        end
        SET_M: begin
          if (any_btn || timeout_hit) blank_mask <= 6'd0;
          else if (tick)              blank_mask <= {2'd0, {2{~blank_mask[3]}}, 2'd0};
        end
        default: blank_mask <= 6'd0;
      endcase
    end
  end
`else
  assign blank_mask = 6'd0;
`endif

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller: directed scenarios followed by
// randomized button/tick traffic, compared every cycle against a time-level model.
module tb_clock_set_controller;

  localparam int TO = 3;
`ifdef BLINK_EN
  localparam logic [5:0] BLINK_H = 6'b110000;
`else
  localparam logic [5:0] BLINK_H = 6'b000000;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [3:0] cur_h1 = 4'd0, cur_h0 = 4'd0, cur_m1 = 4'd0, cur_m0 = 4'd0;
  logic       run_en, load;
  logic [3:0] ld_h1, ld_h0, ld_m1, ld_m0;
  logic [5:0] blank_mask;
  logic [1:0] mode;

  clock_set_controller #(.TIMEOUT_S(TO)) dut (
    .clk(clk), .resetn(resetn), .tick(tick),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .run_en(run_en), .load(load),
    .ld_h1(ld_h1), .ld_h0(ld_h0), .ld_m1(ld_m1), .ld_m0(ld_m0),
    .blank_mask(blank_mask), .mode(mode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int dut_loads = 0;

  // Model: mode number, hours 0..23, minutes 0..59, idle ticks, blink phase.
  int m_mode, m_h, m_m, m_cnt;
  bit m_ph;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_h = 0; m_m = 0; m_cnt = 0; m_ph = 0;
  endtask

  function automatic int san_h();
    int v = int'(cur_h1) * 10 + int'(cur_h0);
    return (cur_h0 > 4'd9 || v > 23) ? 0 : v;
  endfunction

  function automatic int san_m();
    int v = int'(cur_m1) * 10 + int'(cur_m0);
    return (cur_m0 > 4'd9 || v > 59) ? 0 : v;
  endfunction

  task automatic model_step(input bit t, input bit bm, input bit bi, input bit bd);
    bit any = bm | bi | bd;
    int d;
    case (m_mode)
      0: if (bm) begin
           m_mode = 1; m_h = san_h(); m_m = san_m(); m_cnt = 0; m_ph = 0;
         end
      1, 2: begin
        if (bm) begin
          m_mode = m_mode + 1; m_cnt = 0; m_ph = 0;
        end else if (any) begin
          m_cnt = 0; m_ph = 0;
          if (bi != bd) begin
            d = bi ? 1 : -1;
            if (m_mode == 1) m_h = (m_h + 24 + d) % 24;
            else             m_m = (m_m + 60 + d) % 60;
          end
        end else if (t) begin
          m_cnt++;
          if (m_cnt >= TO) begin m_mode = 0; m_ph = 0; end
          else m_ph = ~m_ph;
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  function automatic int exp_mask();
`ifdef BLINK_EN
    if (m_mode == 1 && m_ph) return 6'b110000;
    if (m_mode == 2 && m_ph) return 6'b001100;
`endif
    return 0;
  endfunction

  task automatic compare();
    check("mode",   int'(mode),   m_mode);
    check("run_en", int'(run_en), (m_mode == 0) ? 1 : 0);
    check("load",   int'(load),   (m_mode == 3) ? 1 : 0);
    check("ld_h1",  int'(ld_h1),  m_h / 10);
    check("ld_h0",  int'(ld_h0),  m_h % 10);
    check("ld_m1",  int'(ld_m1),  m_m / 10);
    check("ld_m0",  int'(ld_m0),  m_m % 10);
    check("blank",  int'(blank_mask), exp_mask());
    if (load) dut_loads++;
  endtask

  // Drive one cycle of inputs, advance model at the edge, compare at the falling edge.
  task automatic cycle(input bit t, input bit bm, input bit bi, input bit bd);
    tick = t; btn_mode = bm; btn_inc = bi; btn_dec = bd;
    @(posedge clk);
    model_step(t, bm, bi, bd);
    @(negedge clk);
    compare();
    tick = 0; btn_mode = 0; btn_inc = 0; btn_dec = 0;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic async_reset();
    resetn = 1'b0;
    #2;
    model_reset();
    compare();
    resetn = 1'b1;
    #1;
  endtask

  int loads_before;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    check("rst_mode",   int'(mode), 0);
    check("rst_run_en", int'(run_en), 1);
    resetn = 1'b1;

    // Capture 12:34, then 12 increments wrap hours to 00.
    cur_h1 = 4'd1; cur_h0 = 4'd2; cur_m1 = 4'd3; cur_m0 = 4'd4;
    cycle(0, 1, 0, 0);
    check("enter_mode", int'(mode), 1);
    check("enter_run_en", int'(run_en), 0);
    check("cap_h", int'({ld_h1, ld_h0}), 8'h12);
    check("cap_m", int'({ld_m1, ld_m0}), 8'h34);
    repeat (12) cycle(0, 0, 1, 0);
    check("h_wrap_up", int'({ld_h1, ld_h0}), 8'h00);

    // Minutes 34 -> 00 by 26 increments, then dec wraps to 59; commit.
    cycle(0, 1, 0, 0);
    check("set_m", int'(mode), 2);
    repeat (26) cycle(0, 0, 1, 0);
    check("m_wrap_up", int'({ld_m1, ld_m0}), 8'h00);
    cycle(0, 0, 0, 1);
    check("m_wrap_dn", int'({ld_m1, ld_m0}), 8'h59);
    cycle(0, 1, 0, 0);
    check("commit_load", int'(load), 1);
    check("commit_run_en", int'(run_en), 0);
    check("commit_ld", int'({ld_h1, ld_h0, ld_m1, ld_m0}), 16'h0059);
    cycle(0, 0, 0, 0);
    check("post_commit_load", int'(load), 0);
    check("post_commit_run", int'(run_en), 1);
    check("post_commit_mode", int'(mode), 0);

    // Timeout after three idle ticks, no load.
    loads_before = dut_loads;
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("timeout_mode", int'(mode), 0);
    check("timeout_no_load", dut_loads - loads_before, 0);
    // An inc between ticks 2 and 3 restarts the count.
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    check("timeout_cleared", int'(mode), 1);

    // mode+inc: mode wins; inc+dec: ignored.
    cycle(0, 1, 1, 0);
    check("mode_wins", int'(mode), 2);
    check("mode_wins_h", int'({ld_h1, ld_h0}), 8'h13);
    cycle(0, 0, 1, 1);
    check("incdec_ignored", int'({ld_m1, ld_m0}), 8'h34);

    // Reset while in SET_M: immediate clear, no load afterwards.
    loads_before = dut_loads;
    async_reset();
    check("async_mode", int'(mode), 0);
    check("async_ld", int'({ld_h1, ld_h0, ld_m1, ld_m0}), 0);
    repeat (3) cycle(0, 0, 0, 0);
    check("async_no_load", dut_loads - loads_before, 0);

    // Blink phase in SET_H and forced visible on a button press.
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check("blink_on", int'(blank_mask), int'(BLINK_H));
    cycle(1, 0, 0, 0);
    check("blink_off", int'(blank_mask), 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    check("blink_on2", int'(blank_mask), int'(BLINK_H));
    cycle(0, 0, 1, 0);
    check("blink_btn", int'(blank_mask), 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);

    // Sanitised capture of out-of-range time.
    cur_h1 = 4'd2; cur_h0 = 4'd7; cur_m1 = 4'd6; cur_m0 = 4'd1;
    cycle(0, 1, 0, 0);
    check("san_cap", int'({ld_h1, ld_h0, ld_m1, ld_m0}), 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cur_h1 = 4'($urandom_range(0, 3));
        cur_h0 = 4'($urandom_range(0, 11));
        cur_m1 = 4'($urandom_range(0, 6));
        cur_m0 = 4'($urandom_range(0, 11));
      end
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        cycle($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Front-panel controller for the six-digit BCD seven-segment clock. It sequences the clock counter between free-running and user edit modes, and edits hours and minutes from debounced button pulses. On commit it issues a one-cycle parallel load, with seconds forced to 00. It sits between the button debouncers and the clock counter, gating the counter's advance and driving the display blanking mask.

## Interface
- TIMEOUT_S, 30: number of `tick` pulses without a button press, while editing, before the edit is abandoned. 0 disables the timeout.

- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- tick  in  1  1 Hz strobe, one clk cycle wide
- btn_mode  in  1  debounced one-cycle pulse: enter edit / advance field / commit
- btn_inc  in  1  debounced one-cycle pulse: increment the field being edited
- btn_dec  in  1  debounced one-cycle pulse: decrement the field being edited
- cur_h1, cur_h0, cur_m1, cur_m0  in  4 each  current BCD time from the clock counter
- run_en  out  1  clock counter advances on `tick` only while this is 1
- load  out  1  one-cycle strobe: counter loads the `ld_*` outputs, seconds load 00
- ld_h1, ld_h0, ld_m1, ld_m0  out  4 each  BCD load value (edit registers)
- blank_mask  out  6  per-digit blank: [5:4] hours, [3:2] minutes, [1:0] seconds
- mode  out  2  state: RUN=0, SET_H=1, SET_M=2, COMMIT=3

## Operation
- **RUN**
  - `run_en`=1.
  - `btn_mode` captures `cur_*` into the edit registers, clears the timeout counter and moves to SET_H.
- **SET_H**
  - `btn_inc` steps hours 00→01→…→23→00. `btn_dec` steps 00→23.
  - Both digits are updated together as one BCD value.
  - `btn_mode` moves to SET_M.
- **SET_M**
  - `btn_inc`/`btn_dec` step minutes 00…59 with wrap.
  - `btn_mode` moves to COMMIT.
- **COMMIT**
  - `load`=1 for exactly this cycle.
  - Unconditional move to RUN.
- **Edit registers**
  - Captured edit values are sanitised: hours above 23 become 00, minutes above 59 become 00.
- **Timeout**
  - In SET_H or SET_M, each `tick` increments the timeout counter; any button pulse clears it.
  - When the count reaches TIMEOUT_S, the block returns to RUN with no `load`. The counter resumes from its frozen time.
- **Simultaneous events**
  - `btn_mode` together with `btn_inc`/`btn_dec`: mode wins and the inc/dec is dropped.
  - `btn_inc` and `btn_dec` together: both are ignored.
  - A button pulse in the same cycle as the timeout-reaching `tick`: the button wins and the counter is cleared.
  - `btn_inc`/`btn_dec` in RUN or COMMIT: ignored.
- **Width rules**
  - The timeout counter is $clog2(TIMEOUT_S+1) bits and saturates.
  - BCD digits never hold values above 9.

## Timing
- **Reset values**
  - mode=RUN, run_en=1, load=0, ld_*=0, blank_mask=0, timeout counter=0.
  - Reset mid-edit discards the edits with no `load`.
- **Latencies**
  - All outputs are registered.
  - `btn_mode` sampled in RUN at edge N gives mode=SET_H and run_en=0 from edge N onward (visible the cycle after the press).
  - A `tick` arriving in that press cycle is still honoured by the counter, because run_en was 1 when it was sampled.
  - COMMIT lasts exactly one cycle. `run_en` is 0 during COMMIT and 1 from the following cycle.
  - `ld_*` are stable during the `load` cycle.
  - An inc/dec takes effect on `ld_*` one cycle after the pulse.

## Configuration
- **BLINK_EN defined**
  - In SET_H, each `tick` toggles a blink phase and blank_mask[5:4] follows that phase. In SET_M, blank_mask[3:2] follows it.
  - Any button pulse forces the phase to visible (0).
  - Entering RUN clears blank_mask.
- **BLINK_EN undefined**
  - blank_mask is constant 0 and the blink flop is not built.

## Test plan
- Reset, then at time 12:34 pulse mode → mode=1 and run_en=0 next cycle, ld=12:34. Inc ×12 → ld hours=00 (wrap at 24).
- In SET_M at minutes 00, pulse dec → 59. Mode → exactly one `load` cycle with ld=hh:59, then run_en=1 and mode=0.
- TIMEOUT_S=3: enter SET_H, send 3 ticks with no buttons → mode=0, no `load` seen. Repeat with an inc between ticks 2 and 3 → still in SET_H after 3 ticks.
- In SET_H, drive mode+inc in the same cycle → mode=2 and hours unchanged. Drive inc+dec together → no change.
- Deassert resetn while in SET_M → all outputs return to reset values immediately (asynchronously), and no `load` pulse occurs.
- With BLINK_EN: in SET_H, each tick toggles blank_mask between 6'b110000 and 0, and inc forces it to 0. Without BLINK_EN: blank_mask stays 0 throughout.
